// File: rtl/riscv_decode_stage.sv
// RV32I(+Zicsr) decode stage: fetch FIFO feeding a registered decoder with a
// valid/ready output. Control-field encodings are defined locally below.
module riscv_decode_stage #(
    parameter int DEPTH         = 2,
    parameter int SUPPORT_ZICSR = 1,
    parameter int SUPPORT_MRET  = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             fetch_valid_i,
    output logic             fetch_ready_o,
    input  logic [31:0]      fetched_instr_i,
    input  logic [31:0]      fetched_pc_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [31:0]      dec_pc_o,
    output logic [31:0]      dec_instr_o,
    output logic [26:0]      dec_ctrl_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
    localparam logic [2:0] B_RS2 = 3'd0, B_IMM_I = 3'd1, B_IMM_S = 3'd2, B_IMM_U = 3'd3, B_FOUR = 3'd4;
    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
                           ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                           ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_EQ = 5'd10, ALU_NE = 5'd11,
                           ALU_LT = 5'd12, ALU_GE = 5'd13, ALU_LTU = 5'd14, ALU_GEU = 5'd15;
    localparam logic [2:0] CSR_NONE = 3'd0;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_CSR = 2'd2;
    localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67,
                           OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23,
                           OPC_OPIMM = 7'h13, OPC_OP = 7'h33, OPC_FENCE = 7'h0f, OPC_SYSTEM = 7'h73;
    localparam logic [31:0] MRET_WORD    = 32'h30200073;
    localparam logic [26:0] ILLEGAL_CTRL = 27'h10;

    // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
    // the producer holds its payload stable while valid && !ready.
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty, push, pop;
    logic [31:0]   head_instr, head_pc;
    logic [26:0]   head_ctrl;

    assign fifo_full     = (count == CW'(DEPTH));
    assign fifo_empty    = (count == '0);
    assign fetch_ready_o = !fifo_full && !rst_i;
    assign push          = fetch_valid_i && fetch_ready_o;
    assign pop           = !fifo_empty && (!dec_valid_o || dec_ready_i);
    assign head_instr    = instr_mem[rd_ptr];
    assign head_pc       = pc_mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            instr_mem[wr_ptr] <= fetched_instr_i;
            pc_mem[wr_ptr]    <= fetched_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       legal, csr_we, mem_req, mem_we, gpr_we, is_br, is_jal, is_jalr, is_mret;
    logic [1:0] a_sel, wb_sel;
    logic [2:0] b_sel, csr_op, mem_size;
    logic [4:0] alu_op;

    assign opc = head_instr[6:0];
    assign f3  = head_instr[14:12];
    assign f7  = head_instr[31:25];

    always_comb begin
        legal = 1'b0;  a_sel = A_RS1;  b_sel = B_RS2;  alu_op = ALU_ADD;
        csr_op = CSR_NONE;  csr_we = 1'b0;  mem_req = 1'b0;  mem_we = 1'b0;
        mem_size = 3'd0;  gpr_we = 1'b0;  wb_sel = WB_ALU;
        is_br = 1'b0;  is_jal = 1'b0;  is_jalr = 1'b0;  is_mret = 1'b0;
        case (opc)
            OPC_LUI:   begin legal = 1'b1; a_sel = A_ZERO; b_sel = B_IMM_U; gpr_we = 1'b1; end
            OPC_AUIPC: begin legal = 1'b1; a_sel = A_PC;   b_sel = B_IMM_U; gpr_we = 1'b1; end
            // Jumps compute the link value pc+4 in the ALU; targets are formed downstream.
            OPC_JAL:   begin legal = 1'b1; a_sel = A_PC; b_sel = B_FOUR; gpr_we = 1'b1; is_jal = 1'b1; end
            OPC_JALR:  begin legal = (f3 == 3'b000); a_sel = A_PC; b_sel = B_FOUR; gpr_we = 1'b1; is_jalr = 1'b1; end
            OPC_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                is_br = 1'b1;
                case (f3)
                    3'b000:  alu_op = ALU_EQ;
                    3'b001:  alu_op = ALU_NE;
                    3'b100:  alu_op = ALU_LT;
                    3'b101:  alu_op = ALU_GE;
                    3'b110:  alu_op = ALU_LTU;
                    default: alu_op = ALU_GEU;
                endcase
            end
            OPC_LOAD: begin
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
                b_sel = B_IMM_I; mem_req = 1'b1; mem_size = f3; gpr_we = 1'b1; wb_sel = WB_MEM;
            end
            OPC_STORE: begin
                legal = (f3 < 3'd3);
                b_sel = B_IMM_S; mem_req = 1'b1; mem_we = 1'b1; mem_size = f3;
            end
            OPC_OPIMM: begin
                b_sel  = B_IMM_I; gpr_we = 1'b1;
                alu_op = alu_from_f3(f3, f7[5] && (f3 == 3'b101));
                if (f3 == 3'b001)      legal = (f7 == 7'h00);
                else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                   legal = 1'b1;
            end
            OPC_OP: begin
                gpr_we = 1'b1;
                alu_op = alu_from_f3(f3, f7[5]);
                legal  = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_FENCE: legal = (f3 == 3'b000);
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    legal   = (SUPPORT_MRET != 0) && (head_instr == MRET_WORD);
                    is_mret = 1'b1;
                end else if (f3 != 3'b100) begin
                    // csr_op reuses funct3; set/clear forms only write when rs1/uimm is non-zero.
                    legal  = (SUPPORT_ZICSR != 0);
                    csr_op = f3;
                    csr_we = (f3[1:0] == 2'b01) || (head_instr[19:15] != 5'd0);
                    gpr_we = 1'b1; wb_sel = WB_CSR;
                end
            end
            default: legal = 1'b0;
        endcase
        head_ctrl = legal ? {a_sel, b_sel, alu_op, csr_op, csr_we, mem_req, mem_we, mem_size,
                             gpr_we, wb_sel, 1'b0, is_br, is_jal, is_jalr, is_mret}
                          : ILLEGAL_CTRL;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_valid_o <= 1'b0;
            dec_pc_o    <= '0;
            dec_instr_o <= '0;
            dec_ctrl_o  <= '0;
        end else if (flush_i) begin
            dec_valid_o <= 1'b0;
        end else if (pop) begin
            dec_valid_o <= 1'b1;
            dec_pc_o    <= head_pc;
            dec_instr_o <= head_instr;
            dec_ctrl_o  <= head_ctrl;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_cnt_o <= '0;
        end else if (!flush_i && dec_valid_o && dec_ready_i && dec_ctrl_o[4] && (illegal_cnt_o != '1)) begin
            illegal_cnt_o <= illegal_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: two configurations, a mask/match reference decoder
// and a queue scoreboard drained by a negedge monitor.
module tb_riscv_decode_stage;
  localparam int A_RS1 = 0, A_PC = 1, A_ZERO = 2;
  localparam int B_RS2 = 0, B_I = 1, B_S = 2, B_U = 3, B_FOUR = 4;
  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLL = 2, ALU_SLT = 3, ALU_SLTU = 4, ALU_XOR = 5,
                 ALU_SRL = 6, ALU_SRA = 7, ALU_OR = 8, ALU_AND = 9, ALU_EQ = 10, ALU_NE = 11,
                 ALU_LT = 12, ALU_GE = 13, ALU_LTU = 14, ALU_GEU = 15;
  localparam int CSR_RW = 1;

  logic        clk;
  logic        rst [2], fl [2], fv [2], rdy [2], fr [2], dv [2];
  logic [31:0] fin [2], fpc [2], dpc [2], dins [2];
  logic [26:0] dctrl [2];
  logic [15:0] cnt0, cnt_v [2];
  logic [1:0]  cnt1;

  assign cnt_v[0] = cnt0;
  assign cnt_v[1] = {14'd0, cnt1};

  riscv_decode_stage #(.DEPTH(2), .SUPPORT_ZICSR(1), .SUPPORT_MRET(1), .CNT_W(16)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .flush_i(fl[0]), .fetch_valid_i(fv[0]), .fetch_ready_o(fr[0]),
    .fetched_instr_i(fin[0]), .fetched_pc_i(fpc[0]), .dec_valid_o(dv[0]), .dec_ready_i(rdy[0]),
    .dec_pc_o(dpc[0]), .dec_instr_o(dins[0]), .dec_ctrl_o(dctrl[0]), .illegal_cnt_o(cnt0));

  riscv_decode_stage #(.DEPTH(4), .SUPPORT_ZICSR(0), .SUPPORT_MRET(0), .CNT_W(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .flush_i(fl[1]), .fetch_valid_i(fv[1]), .fetch_ready_o(fr[1]),
    .fetched_instr_i(fin[1]), .fetched_pc_i(fpc[1]), .dec_valid_o(dv[1]), .dec_ready_i(rdy[1]),
    .dec_pc_o(dpc[1]), .dec_instr_o(dins[1]), .dec_ctrl_o(dctrl[1]), .illegal_cnt_o(cnt1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0, n_errors = 0;

  task automatic chk(string name, int u, logic [95:0] act, logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s unit%0d: got %h expected %h at %0t", name, u, act, exp, $time);
    end
  endtask

  // reference decoder: instruction-set mask/match table
  function automatic bit hit(logic [31:0] w, logic [31:0] mask, logic [31:0] val);
    return (w & mask) == val;
  endfunction

  function automatic logic [26:0] mk(int a, int b, int alu, int cop, int cwe, int mrq, int mwe,
                                     int msz, int gwe, int wb, int br, int jl, int jr, int mr);
    return {2'(a), 3'(b), 5'(alu), 3'(cop), 1'(cwe), 1'(mrq), 1'(mwe), 3'(msz), 1'(gwe), 2'(wb),
            1'b0, 1'(br), 1'(jl), 1'(jr), 1'(mr)};
  endfunction

  function automatic logic [26:0] ref_ctrl(logic [31:0] w, bit zicsr, bit mret_en);
    int f3;
    int alu;
    f3  = int'(w[14:12]);
    alu = -1;
    if (hit(w, 32'h7f, 32'h37)) return mk(A_ZERO, B_U, ALU_ADD, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    if (hit(w, 32'h7f, 32'h17)) return mk(A_PC, B_U, ALU_ADD, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    if (hit(w, 32'h7f, 32'h6f)) return mk(A_PC, B_FOUR, ALU_ADD, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    if (hit(w, 32'h707f, 32'h67)) return mk(A_PC, B_FOUR, ALU_ADD, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    if (hit(w, 32'h707f, 32'h0063)) alu = ALU_EQ;
    if (hit(w, 32'h707f, 32'h1063)) alu = ALU_NE;
    if (hit(w, 32'h707f, 32'h4063)) alu = ALU_LT;
    if (hit(w, 32'h707f, 32'h5063)) alu = ALU_GE;
    if (hit(w, 32'h707f, 32'h6063)) alu = ALU_LTU;
    if (hit(w, 32'h707f, 32'h7063)) alu = ALU_GEU;
    if (alu >= 0) return mk(A_RS1, B_RS2, alu, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    if (hit(w, 32'h707f, 32'h0003) || hit(w, 32'h707f, 32'h1003) || hit(w, 32'h707f, 32'h2003) ||
        hit(w, 32'h707f, 32'h4003) || hit(w, 32'h707f, 32'h5003))
      return mk(A_RS1, B_I, ALU_ADD, 0, 0, 1, 0, f3, 1, 1, 0, 0, 0, 0);
    if (hit(w, 32'h707f, 32'h0023) || hit(w, 32'h707f, 32'h1023) || hit(w, 32'h707f, 32'h2023))
      return mk(A_RS1, B_S, ALU_ADD, 0, 0, 1, 1, f3, 0, 0, 0, 0, 0, 0);
    if (hit(w, 32'h707f, 32'h0013)) alu = ALU_ADD;
    if (hit(w, 32'h707f, 32'h2013)) alu = ALU_SLT;
    if (hit(w, 32'h707f, 32'h3013)) alu = ALU_SLTU;
    if (hit(w, 32'h707f, 32'h4013)) alu = ALU_XOR;
    if (hit(w, 32'h707f, 32'h6013)) alu = ALU_OR;
    if (hit(w, 32'h707f, 32'h7013)) alu = ALU_AND;
    if (hit(w, 32'hfe00707f, 32'h1013)) alu = ALU_SLL;
    if (hit(w, 32'hfe00707f, 32'h5013)) alu = ALU_SRL;
    if (hit(w, 32'hfe00707f, 32'h40005013)) alu = ALU_SRA;
    if (alu >= 0) return mk(A_RS1, B_I, alu, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    if (hit(w, 32'hfe00707f, 32'h0033)) alu = ALU_ADD;
    if (hit(w, 32'hfe00707f, 32'h40000033)) alu = ALU_SUB;
    if (hit(w, 32'hfe00707f, 32'h1033)) alu = ALU_SLL;
    if (hit(w, 32'hfe00707f, 32'h2033)) alu = ALU_SLT;
    if (hit(w, 32'hfe00707f, 32'h3033)) alu = ALU_SLTU;
    if (hit(w, 32'hfe00707f, 32'h4033)) alu = ALU_XOR;
    if (hit(w, 32'hfe00707f, 32'h5033)) alu = ALU_SRL;
    if (hit(w, 32'hfe00707f, 32'h40005033)) alu = ALU_SRA;
    if (hit(w, 32'hfe00707f, 32'h6033)) alu = ALU_OR;
    if (hit(w, 32'hfe00707f, 32'h7033)) alu = ALU_AND;
    if (alu >= 0) return mk(A_RS1, B_RS2, alu, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    if (hit(w, 32'h707f, 32'h000f)) return 27'd0;
    if (mret_en && w == 32'h30200073) return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    if (zicsr && (hit(w, 32'h707f, 32'h1073) || hit(w, 32'h707f, 32'h2073) || hit(w, 32'h707f, 32'h3073) ||
                  hit(w, 32'h707f, 32'h5073) || hit(w, 32'h707f, 32'h6073) || hit(w, 32'h707f, 32'h7073)))
      return mk(0, 0, 0, f3, int'((f3 == 1) || (f3 == 5) || (w[19:15] != 5'd0)), 0, 0, 0, 1, 2, 0, 0, 0, 0);
    return 27'h10;
  endfunction

  // scoreboard + monitor
  logic [90:0] exp_q [2][$];
  logic [15:0] mcnt [2];
  logic [15:0] cnt_max [2];
  bit          hold [2];
  bit          zic [2], mrt [2];
  logic [90:0] held [2];
  logic [90:0] cur_v, e_v;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      cur_v = {dpc[u], dins[u], dctrl[u]};
      if (hold[u]) chk("hold_stable", u, 96'(cur_v), 96'(held[u]));
      chk("illegal_cnt", u, 96'(cnt_v[u]), 96'(mcnt[u]));
      hold[u] = 1'b0;
      if (rst[u]) begin
        exp_q[u].delete();
        mcnt[u] = 16'd0;
      end else if (fl[u]) begin
        exp_q[u].delete();
      end else begin
        if (dv[u] && rdy[u]) begin
          if (exp_q[u].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat unit%0d: got pc=%h instr=%h expected no beat", u, dpc[u], dins[u]);
          end else begin
            e_v = exp_q[u].pop_front();
            chk("decoded_beat", u, 96'(cur_v), 96'(e_v));
            if (e_v[4] && mcnt[u] != cnt_max[u]) mcnt[u] = mcnt[u] + 16'd1;
          end
        end
        if (fv[u] && fr[u]) exp_q[u].push_back({fpc[u], fin[u], ref_ctrl(fin[u], zic[u], mrt[u])});
        hold[u] = dv[u] && !rdy[u];
        held[u] = cur_v;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(int u, logic [31:0] ins, logic [31:0] pc, output bit took);
    fv[u] = 1'b1; fin[u] = ins; fpc[u] = pc;
    @(negedge clk);
    took = fr[u];
    tick();
    fv[u] = 1'b0;
  endtask

  task automatic send(int u, logic [31:0] ins, logic [31:0] pc);
    bit took;
    for (int i = 0; i < 40; i++) begin
      offer(u, ins, pc, took);
      if (took) return;
    end
    chk("send_timeout", u, 96'(0), 96'(1));
  endtask

  task automatic get_next(int u, output logic [26:0] c);
    bit seen;
    seen = 1'b0;
    c = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (dv[u]) begin seen = 1'b1; c = dctrl[u]; end
    end
    if (!seen) chk("get_next_timeout", u, 96'(0), 96'(1));
    tick();
    rdy[u] = 1'b1;
    tick();
    rdy[u] = 1'b0;
  endtask

  task automatic drain(int u);
    rdy[u] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (exp_q[u].size() == 0 && !dv[u]) return;
    end
    chk("drain_timeout", u, 96'(exp_q[u].size()), 96'(0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [11];
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
    w = $urandom;
    case ($urandom_range(0, 11))
      0: return w;
      1: return 32'h30200073;
      2: return ($urandom_range(0, 1) != 0) ? 32'h00000073 : 32'h00100073;
      default: begin
        w[6:0] = opcs[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
      end
    endcase
  endfunction

  logic [26:0] c;
  bit          took;
  int          k;

  initial begin
    zic = '{1'b1, 1'b0};
    mrt = '{1'b1, 1'b0};
    cnt_max = '{16'hffff, 16'd3};
    mcnt = '{16'd0, 16'd0};
    hold = '{1'b0, 1'b0};
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; fl[u] = 1'b0; fv[u] = 1'b0; rdy[u] = 1'b0; fin[u] = '0; fpc[u] = '0;
    end

    // reset state
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_dec_valid", u, 96'(dv[u]), 96'(0));
      chk("rst_dec_pc", u, 96'(dpc[u]), 96'(0));
      chk("rst_dec_instr", u, 96'(dins[u]), 96'(0));
      chk("rst_dec_ctrl", u, 96'(dctrl[u]), 96'(0));
      chk("rst_cnt", u, 96'(cnt_v[u]), 96'(0));
      chk("rst_fetch_ready", u, 96'(fr[u]), 96'(0));
    end
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) chk("fetch_ready_after_rst", u, 96'(fr[u]), 96'(1));
    tick();

    // addi latency and decode
    rdy[0] = 1'b1;
    offer(0, 32'h00500093, 32'h100, took);
    chk("addi_accepted", 0, 96'(took), 96'(1));
    @(negedge clk);
    chk("latency_not_early", 0, 96'(dv[0]), 96'(0));
    @(negedge clk);
    chk("latency_valid", 0, 96'(dv[0]), 96'(1));
    chk("addi_alu_op", 0, 96'(dctrl[0][21:17]), 96'(ALU_ADD));
    chk("addi_b_sel", 0, 96'(dctrl[0][24:22]), 96'(B_I));
    chk("addi_gpr_we", 0, 96'(dctrl[0][7]), 96'(1));
    chk("addi_illegal", 0, 96'(dctrl[0][4]), 96'(0));
    tick();
    drain(0);

    // all-zero word and ebreak are illegal
    rdy[0] = 1'b0;
    send(0, 32'h00000000, 32'h110);
    send(0, 32'h00100073, 32'h114);
    get_next(0, c);
    chk("zero_word_ctrl", 0, 96'(c), 96'(27'h10));
    get_next(0, c);
    chk("ebreak_ctrl", 0, 96'(c), 96'(27'h10));
    tick();
    chk("illegal_cnt_two", 0, 96'(cnt0), 96'(2));

    // mret / csrrw enabled vs disabled
    send(0, 32'h30200073, 32'h120);
    get_next(0, c);
    chk("mret_ctrl", 0, 96'(c), 96'(27'h1));
    send(0, 32'h34029073, 32'h124);
    get_next(0, c);
    chk("csrrw_csr_we", 0, 96'(c[13]), 96'(1));
    chk("csrrw_csr_op", 0, 96'(c[16:14]), 96'(CSR_RW));
    chk("csrrw_wb_sel", 0, 96'(c[6:5]), 96'(2));
    send(1, 32'h30200073, 32'h120);
    get_next(1, c);
    chk("mret_disabled", 1, 96'(c), 96'(27'h10));
    send(1, 32'h34029073, 32'h124);
    get_next(1, c);
    chk("csr_disabled", 1, 96'(c), 96'(27'h10));

    // capacity under full stall: DEPTH + 1
    rdy[0] = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 8 && k < 4; cyc++) begin
      offer(0, 32'h00100093 + (k << 20), 32'h200 + 32'(k * 4), took);
      if (took) k++;
    end
    chk("capacity_accepted", 0, 96'(k), 96'(3));
    @(negedge clk);
    chk("capacity_fetch_ready", 0, 96'(fr[0]), 96'(0));
    repeat (3) tick();
    drain(0);

    // flush with a simultaneous fetch beat
    rdy[0] = 1'b0;
    send(0, 32'h00a00113, 32'h300);
    send(0, 32'h00b00113, 32'h304);
    send(0, 32'h00c00113, 32'h308);
    tick();
    fl[0] = 1'b1; fv[0] = 1'b1; fin[0] = 32'h00d00113; fpc[0] = 32'h3ff;
    tick();
    fl[0] = 1'b0; fv[0] = 1'b0;
    @(negedge clk);
    chk("flush_dec_valid", 0, 96'(dv[0]), 96'(0));
    chk("flush_fetch_ready", 0, 96'(fr[0]), 96'(1));
    rdy[0] = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("flush_fifo_empty", 0, 96'(dv[0]), 96'(0));
    tick();

    // randomized traffic on both configurations
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int u = 0; u < 2; u++) begin
        fv[u]  = ($urandom_range(0, 3) != 0);
        fin[u] = rand_instr();
        fpc[u] = 32'h1000 + 32'(cyc * 4);
        rdy[u] = ($urandom_range(0, 3) != 0);
        fl[u]  = ($urandom_range(0, 99) == 0);
      end
      tick();
    end
    for (int u = 0; u < 2; u++) begin fv[u] = 1'b0; fl[u] = 1'b0; end
    drain(0);
    drain(1);

    // counter saturation with CNT_W = 2
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    rdy[1] = 1'b1;
    for (int i = 0; i < 5; i++) send(1, 32'h00000000, 32'h500 + 32'(i * 4));
    drain(1);
    tick();
    @(negedge clk);
    chk("cnt_saturated", 1, 96'(cnt1), 96'(3));
    tick();

    // reset mid-stream
    rdy[1] = 1'b0;
    send(1, 32'h00500093, 32'h600);
    send(1, 32'h00600093, 32'h604);
    tick();
    rst[1] = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_dec_valid", 1, 96'(dv[1]), 96'(0));
    chk("midrst_dec_pc", 1, 96'(dpc[1]), 96'(0));
    chk("midrst_dec_instr", 1, 96'(dins[1]), 96'(0));
    chk("midrst_dec_ctrl", 1, 96'(dctrl[1]), 96'(0));
    chk("midrst_cnt", 1, 96'(cnt1), 96'(0));
    chk("midrst_fetch_ready", 1, 96'(fr[1]), 96'(0));
    tick();
    rst[1] = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
